exp_sig_seq: RTL
================

// Module: exp_sig_seq
// PURPOSE
//  Test-pattern sequencer for exp_sig_gen. Holds a small table of generator set-ups
//  (delay, overlay, rate, repeat count) and plays them back in order on a start command.
//  It drives the generator's overlay/rate/delay inputs and its active-low reset, so every
//  entry begins from a clean ROM/RAM address origin. It sits between the control
//  registers and exp_sig_gen in the filter test bench and the FPGA test mode.
// PARAMETERS
//  SIZE_DELAY   10    width of delay field; matches exp_sig_gen delay port
//  TABLE_DEPTH  8     number of table entries (power of 2, >=2)
//  SIZE_REPEAT  8     width of per-entry frame repeat count
//  FRAME_LEN    2048  clocks per generator frame (one rm_addr wrap of the generator)
//  SETTLE_CYC   4     clocks gen_reset is held low before each entry (>=1)
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  asynchronous reset, active-high
//  cfg_we       in   1                  table write strobe
//  cfg_addr     in   log2(TABLE_DEPTH)  table write address
//  cfg_delay    in   SIZE_DELAY         entry delay value
//  cfg_overlay  in   1                  entry overlay enable
//  cfg_rate     in   1                  entry rate-modulation enable
//  cfg_repeat   in   SIZE_REPEAT        entry frame count (0 treated as 1)
//  num_entries  in   log2(TABLE_DEPTH)+1  entries to play, sampled on start
//  start        in   1                  start sequence (level sampled per clk)
//  stop         in   1                  abort sequence
//  busy         out  1                  sequence in progress
//  done         out  1                  1-clk pulse at normal sequence end
//  cur_entry    out  log2(TABLE_DEPTH)  entry being played
//  frame_strobe out  1                  1-clk pulse on first clk of each frame
//  gen_reset    out  1                  to exp_sig_gen reset (active-low)
//  overlay      out  1                  to exp_sig_gen overlay
//  rate         out  1                  to exp_sig_gen rate
//  delay        out  SIZE_DELAY         to exp_sig_gen delay
// BEHAVIOUR
//  Reset: all outputs 0 (gen_reset=0 holds generator), table cleared, state IDLE.
//  FSM: IDLE -> LOAD -> HOLD -> RUN -> NEXT -> (LOAD | DONE) -> IDLE.
//   IDLE: start=1 & num_entries!=0 -> LOAD, cur_entry=0, busy=1 next clk.
//         start=1 & num_entries==0 -> DONE directly (done pulse, no generator run).
//   LOAD (1 clk): overlay/rate/delay registered from table[cur_entry]; gen_reset=0.
//   HOLD (SETTLE_CYC clks): gen_reset=0; outputs stable.
//   RUN: gen_reset=1; frame counter 0..FRAME_LEN-1, frame_strobe when counter==0;
//        after max(repeat,1) frames -> NEXT.
//   NEXT (1 clk): gen_reset=0; cur_entry+1; if cur_entry+1==num_entries -> DONE else LOAD.
//   DONE (1 clk): done=1, busy=0 next clk; overlay/rate/delay keep last values.
//  Latency: start sampled at edge N -> busy=1 and new config at N+1; gen_reset rises at
//   N+1+SETTLE_CYC+1... exactly: LOAD at N+1, HOLD N+2..N+1+SETTLE_CYC, RUN from N+2+SETTLE_CYC.
//  Per entry: 1 + SETTLE_CYC + repeat*FRAME_LEN + 1 clocks.
//  start while busy: ignored. stop while busy: next clk IDLE, gen_reset=0, busy=0, no done.
//  start & stop same clk in IDLE: stop wins, stays IDLE.
//  cfg_we while busy: ignored (table frozen); cfg_we in IDLE: written next edge.
//  num_entries > TABLE_DEPTH: clamped to TABLE_DEPTH.
//  reset asserted mid-sequence: immediate return to reset values, table cleared.
// CONFIGURATION
//  EXP_SEQ_LOOP_EN defined: NEXT on last entry wraps to entry 0 (-> LOAD); only stop or
//   reset end the sequence; done never pulses.
//  Not defined: sequence ends in DONE after last entry as above.
// TESTING (bench: FRAME_LEN=16, SETTLE_CYC=2, TABLE_DEPTH=8)
//  Reset mid-RUN -> all outputs 0 same clk, table reads back 0, state IDLE.
//  Write e0={delay=5,ov=1,rate=0,rep=2}, num_entries=1, start -> gen_reset low 3 clks,
//   high 32 clks, 2 frame_strobes 16 apart, delay=5 overlay=1, done at clk 36, busy drops.
//  Entries e0 rep=1, e1 rep=0 (as 1), num=2 -> cur_entry 0 then 1, gen_reset low between,
//   total 2*(1+2+16+1)=40 clks to done.
//  stop asserted at 5th RUN clk -> busy=0, gen_reset=0 next clk, no done pulse.
//  num_entries=0 start -> done next clk, gen_reset never high; start & stop together -> no busy.
//  EXP_SEQ_LOOP_EN, num=2 -> cur_entry 0,1,0,1... for 200 clks, done never 1 until stop.

Source files
------------

// File: rtl/exp_sig_seq_if.sv
// Bundle of the table-write, command and generator-drive signals for exp_sig_seq.
// Suffixes are relative to the sequencer: _i flows into it, _o flows out of it.
interface exp_sig_seq_if #(
    parameter int SIZE_DELAY  = 10,
    parameter int TABLE_DEPTH = 8,
    parameter int SIZE_REPEAT = 8
);
    localparam int AW = $clog2(TABLE_DEPTH);

    logic                   cfg_we_i;
    logic [AW-1:0]          cfg_addr_i;
    logic [SIZE_DELAY-1:0]  cfg_delay_i;
    logic                   cfg_overlay_i;
    logic                   cfg_rate_i;
    logic [SIZE_REPEAT-1:0] cfg_repeat_i;
    logic [AW:0]            num_entries_i;
    logic                   start_i;
    logic                   stop_i;
    logic                   busy_o;
    logic                   done_o;
    logic [AW-1:0]          cur_entry_o;
    logic                   frame_strobe_o;
    logic                   gen_reset_o;
    logic                   overlay_o;
    logic                   rate_o;
    logic [SIZE_DELAY-1:0]  delay_o;
    logic [2:0]             dbg_state_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_delay_i, cfg_overlay_i, cfg_rate_i, cfg_repeat_i,
        output num_entries_i, start_i, stop_i,
        input  busy_o, done_o, cur_entry_o, frame_strobe_o, gen_reset_o,
        input  overlay_o, rate_o, delay_o, dbg_state_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_delay_i, cfg_overlay_i, cfg_rate_i, cfg_repeat_i,
        input  num_entries_i, start_i, stop_i,
        output busy_o, done_o, cur_entry_o, frame_strobe_o, gen_reset_o,
        output overlay_o, rate_o, delay_o, dbg_state_o
    );
endinterface

// File: rtl/exp_sig_seq.sv
// Test-pattern sequencer for exp_sig_gen: plays a table of generator set-ups in order.
// Optional EXP_SEQ_LOOP_EN: wrap from the last entry back to entry 0 until stop/reset.
module exp_sig_seq #(
    parameter int SIZE_DELAY  = 10,
    parameter int TABLE_DEPTH = 8,
    parameter int SIZE_REPEAT = 8,
    parameter int FRAME_LEN   = 2048,
    parameter int SETTLE_CYC  = 4
) (
    input logic          clk,
    input logic          reset,
    exp_sig_seq_if.slave bus
);
    localparam int AW = $clog2(TABLE_DEPTH);
    localparam int NW = AW + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Command semantics: start_i and stop_i are levels sampled on every clk edge, no
    // handshake. start_i is acted on only in IDLE; stop_i aborts any non-IDLE state and
    // beats a simultaneous start_i. cfg_we_i writes the table only while IDLE.

    state_t                 state_q, state_d;
    logic [AW-1:0]          cur_q, cur_d;
    logic [NW-1:0]          num_q, num_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [SIZE_REPEAT-1:0] rep_cnt_q, rep_cnt_d;
    logic [SIZE_REPEAT-1:0] rep_tgt_q, rep_tgt_d;
    logic                   overlay_q, overlay_d;
    logic                   rate_q, rate_d;
    logic [SIZE_DELAY-1:0]  delay_q, delay_d;

    logic [SIZE_DELAY-1:0]  tbl_delay_q   [TABLE_DEPTH];
    logic                   tbl_overlay_q [TABLE_DEPTH];
    logic                   tbl_rate_q    [TABLE_DEPTH];
    logic [SIZE_REPEAT-1:0] tbl_repeat_q  [TABLE_DEPTH];

    logic                   load_cfg;
    logic [AW-1:0]          load_idx;
    logic                   last_entry;
    logic [NW-1:0]          num_clamped;

    assign num_clamped = (bus.num_entries_i > NW'(TABLE_DEPTH)) ? NW'(TABLE_DEPTH)
                                                                 : bus.num_entries_i;
    assign last_entry  = (({1'b0, cur_q} + NW'(1)) == num_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                tbl_delay_q[i]   <= '0;
                tbl_overlay_q[i] <= 1'b0;
                tbl_rate_q[i]    <= 1'b0;
                tbl_repeat_q[i]  <= '0;
            end
        end else if (bus.cfg_we_i && (state_q == S_IDLE)) begin
            tbl_delay_q[bus.cfg_addr_i]   <= bus.cfg_delay_i;
            tbl_overlay_q[bus.cfg_addr_i] <= bus.cfg_overlay_i;
            tbl_rate_q[bus.cfg_addr_i]    <= bus.cfg_rate_i;
            tbl_repeat_q[bus.cfg_addr_i]  <= bus.cfg_repeat_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            num_q     <= '0;
            hold_q    <= '0;
            frame_q   <= '0;
            rep_cnt_q <= '0;
            rep_tgt_q <= '0;
            overlay_q <= 1'b0;
            rate_q    <= 1'b0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            num_q     <= num_d;
            hold_q    <= hold_d;
            frame_q   <= frame_d;
            rep_cnt_q <= rep_cnt_d;
            rep_tgt_q <= rep_tgt_d;
            overlay_q <= overlay_d;
            rate_q    <= rate_d;
            delay_q   <= delay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        num_d     = num_q;
        hold_d    = hold_q;
        frame_d   = frame_q;
        rep_cnt_d = rep_cnt_q;
        rep_tgt_d = rep_tgt_q;
        overlay_d = overlay_q;
        rate_d    = rate_q;
        delay_d   = delay_q;
        load_cfg  = 1'b0;
        load_idx  = cur_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.stop_i && bus.start_i) begin
                    num_d = num_clamped;
                    if (bus.num_entries_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                        cur_d    = '0;
                        load_cfg = 1'b1;
                        load_idx = '0;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_HOLD;
                hold_d  = '0;
            end
            S_HOLD: begin
                if (hold_q == HW'(SETTLE_CYC - 1)) begin
                    state_d   = S_RUN;
                    frame_d   = '0;
                    rep_cnt_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                if (frame_q == FW'(FRAME_LEN - 1)) begin
                    frame_d = '0;
                    if (rep_cnt_q == rep_tgt_q - SIZE_REPEAT'(1)) state_d = S_NEXT;
                    else rep_cnt_d = rep_cnt_q + SIZE_REPEAT'(1);
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end
            S_NEXT: begin
                if (last_entry) begin
`ifdef EXP_SEQ_LOOP_EN
                    state_d  = S_LOAD;
                    cur_d    = '0;
                    load_cfg = 1'b1;
                    load_idx = '0;
`else
                    state_d  = S_DONE;
`endif
                end else begin
                    state_d  = S_LOAD;
                    cur_d    = cur_q + AW'(1);
                    load_cfg = 1'b1;
                    load_idx = cur_q + AW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (bus.stop_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            load_cfg = 1'b0;
        end

        // A zero repeat count plays one frame, so the target is never 0.
        if (load_cfg) begin
            overlay_d = tbl_overlay_q[load_idx];
            rate_d    = tbl_rate_q[load_idx];
            delay_d   = tbl_delay_q[load_idx];
            rep_tgt_d = (tbl_repeat_q[load_idx] == '0) ? SIZE_REPEAT'(1)
                                                       : tbl_repeat_q[load_idx];
        end
    end

    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.done_o         = (state_q == S_DONE);
    assign bus.gen_reset_o    = (state_q == S_RUN);
    assign bus.frame_strobe_o = (state_q == S_RUN) && (frame_q == '0);
    assign bus.cur_entry_o    = cur_q;
    assign bus.overlay_o      = overlay_q;
    assign bus.rate_o         = rate_q;
    assign bus.delay_o        = delay_q;
    assign bus.dbg_state_o    = state_q;
endmodule
